filt_ppi_oq: RTL and testbench
==============================

# filt_ppi_oq

Output quantizer and elastic buffer for the polyphase interpolator. It sits directly downstream of `filt_ppi` in the fast-clock domain and takes one full-precision interpolated sample per strobe. Each sample is rounded (or truncated), then saturated to the system sample width. Results are queued in a small FIFO and presented to the next stage through a valid/ready handshake, so back-pressure never stalls the interpolator.

## Interface
- `gp_idata_width`, 26: input sample width; signed; matches the `filt_ppi` output width.
- `gp_odata_width`, 16: output sample width; signed.
- `gp_frac_drop`, 10: number of LSBs discarded; must be ≥1 and ≤ `gp_idata_width` − 2.
- `gp_fifo_depth`, 8: FIFO entries; power of two, ≥2.

- `i_clk`  in  1  rising-edge clock; the `filt_ppi` fast clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  one-cycle strobe; `i_data` is valid.
- `i_data`  in  `gp_idata_width`  signed full-precision sample.
- `o_data`  out  `gp_odata_width`  signed quantized sample at the FIFO head.
- `o_valid`  out  1  FIFO not empty.
- `i_ready`  in  1  downstream accepts `o_data` this cycle.
- `o_level`  out  clog2(`gp_fifo_depth`)+1  current FIFO occupancy.
- `o_sat`  out  1  one-cycle pulse when the registered sample was clipped.
- `o_ovf`  out  1  sticky; a sample was dropped because the FIFO was full.

## Operation
- **Quantize stage (registered):**
  - `s = i_data + R`, computed in `gp_idata_width`+1 bits. `R = 2^(gp_frac_drop−1)` when rounding is compiled in, otherwise 0.
  - `q = s >>> gp_frac_drop`, an arithmetic shift.
  - If `q` exceeds `+2^(gp_odata_width−1)−1` or falls below `−2^(gp_odata_width−1)`, clamp it to that limit and pulse `o_sat`.
  - The stage registers `q_data` and `q_valid`.
- **FIFO:**
  - Circular buffer with read and write pointers one bit wider than the address.
  - Write when `q_valid` and (not full, or a read happens in the same cycle).
  - If `q_valid` and full with no read, drop the sample and set `o_ovf`.
  - Read when `o_valid` and `i_ready`.
  - `o_data` is show-ahead: it is the memory at the read pointer, and is held at 0 while empty.
  - Simultaneous read and write leaves `o_level` unchanged. A read while empty is ignored.
  - Pointers wrap modulo 2·depth. Full means the MSBs differ and the address bits are equal.
- **Reset:**
  - `o_valid`, `o_data`, `o_level`, `o_sat` and `o_ovf` are all 0.
  - Pointers and `q_valid` are cleared.
  - Asserting reset mid-stream flushes all queued samples and discards the sample in flight. Memory contents need not be cleared.
- `o_ovf` is cleared only by reset.

## Timing
- `i_valid` high in cycle N → `q_valid` and `o_sat` in N+1 → FIFO write at the end of N+1 → `o_valid`=1 and `o_data` valid in N+2, provided the FIFO was empty.
- Throughput: one sample per cycle sustained while `i_ready`=1.
- `o_level` updates on the same edge as the pointers.
- With the FIFO full and `i_ready`=1, the incoming write is accepted in the same cycle. There is no bubble and no overflow.

## Configuration
- `FILT_PPI_OQ_ROUND_EN` defined: round-half-up, using the R above.
- Not defined: pure truncation (R=0), which is floor toward −∞. The adder is omitted.
- Saturation and the FIFO are always present.

## Structure
- The shared package `filt_pkg` holds:
  - a `clog2` function;
  - a saturation-limit function taking (width, sign).
- Natural sub-module: `sync_fifo`, a single-clock show-ahead FIFO with a level output. The quantize stage stays inline.

## Test plan
Defaults apply unless stated.
- **Rounding:** `i_data` = 1536 → `o_data` = 2 with `FILT_PPI_OQ_ROUND_EN`, 1 without. `i_data` = −512 → 0 with round, −1 without. `o_valid` rises 2 cycles after the strobe.
- **Saturation:** `i_data` = 33554431 with round → `o_data` = 32767, `o_sat` pulses once. `i_data` = −33554432 → −32768 with no `o_sat`.
- **Overflow:** hold `i_ready`=0 and send 10 strobes → `o_level`=8, `o_ovf`=1. Draining yields samples 1–8 in order and samples 9–10 are lost.
- **Full with read:** FIFO full, `i_ready`=1, continuous strobes → `o_level` stays 8, `o_ovf` stays 0, output stream is gap-free.
- **Wrap-around:** 100 samples with random `i_ready` → output matches the reference quantizer model sample-for-sample, and `o_level` never exceeds 8.
- **Reset mid-stream:** 5 samples queued, assert `i_rst` for 1 cycle → `o_valid`=0, `o_level`=0, `o_ovf`=0 next cycle. The in-flight sample never appears.

Source files
------------

// File: rtl/filt_pkg.sv
// filt_pkg: shared helpers for the polyphase interpolator filter blocks.
//   clog2      - ceiling log2 for sizing pointers and level counters.
//   sat_limit  - signed saturation bound for a given width; upper=1 gives the
//                most positive value, upper=0 the most negative.
package filt_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  function automatic longint sat_limit(input int unsigned width, input logic upper);
    longint one;
    one = 1;
    if (upper) begin
      return (one <<< (width - 1)) - one;
    end
    return -(one <<< (width - 1));
  endfunction

endpackage

// File: rtl/filt_ppi_oq_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with occupancy output.
//   i_clk, i_rst  - clock, synchronous active-high reset (clears pointers only)
//   i_wr_en       - write request; accepted when not full or when a read
//                   happens in the same cycle
//   i_wr_data     - write data
//   i_rd_en       - read request; ignored while empty
//   o_rd_data     - entry at the read pointer, 0 while empty
//   o_empty       - no entries
//   o_full        - gp_depth entries
//   o_level       - current occupancy, 0..gp_depth
// gp_depth must be a power of two, >= 2.
module sync_fifo
  import filt_pkg::*;
#(
  parameter int unsigned gp_width = 16,
  parameter int unsigned gp_depth = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_wr_en,
  input  logic [gp_width-1:0]       i_wr_data,
  input  logic                      i_rd_en,
  output logic [gp_width-1:0]       o_rd_data,
  output logic                      o_empty,
  output logic                      o_full,
  output logic [clog2(gp_depth):0]  o_level
);

  localparam int unsigned AW = clog2(gp_depth);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic [gp_width-1:0] mem_q [gp_depth];
  logic                do_wr;
  logic                do_rd;

  always_comb begin
    o_empty  = (wr_ptr_q == rd_ptr_q);
    o_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_rd    = i_rd_en && !o_empty;
    // A read in the same cycle frees a slot, so a full FIFO still accepts.
    do_wr    = i_wr_en && (!o_full || do_rd);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    o_level  = wr_ptr_q - rd_ptr_q;
    o_rd_data = o_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_wr_data;
    end
  end

endmodule

// File: rtl/filt_ppi_oq.sv
// filt_ppi_oq: output quantizer and elastic buffer for the polyphase
// interpolator. Each strobed full-precision sample is rounded (or truncated),
// saturated to gp_odata_width and queued in a show-ahead FIFO drained by a
// valid/ready handshake.
//   i_clk, i_rst - fast clock, synchronous active-high reset
//   i_valid      - one-cycle strobe qualifying i_data
//   i_data       - signed full-precision sample
//   o_data       - signed quantized sample at the FIFO head (0 while empty)
//   o_valid      - FIFO not empty
//   i_ready      - downstream accepts o_data this cycle
//   o_level      - FIFO occupancy
//   o_sat        - one-cycle pulse when the registered sample was clipped
//   o_ovf        - sticky; a sample was dropped on a full FIFO
// Build option: define FILT_PPI_OQ_ROUND_EN for round-half-up; otherwise the
// quantizer truncates (floor toward minus infinity).
module filt_ppi_oq
  import filt_pkg::*;
#(
  parameter int unsigned gp_idata_width = 26,
  parameter int unsigned gp_odata_width = 16,
  parameter int unsigned gp_frac_drop   = 10,
  parameter int unsigned gp_fifo_depth  = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  input  logic [gp_idata_width-1:0]      i_data,
  output logic [gp_odata_width-1:0]      o_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [clog2(gp_fifo_depth):0]  o_level,
  output logic                           o_sat,
  output logic                           o_ovf
);

  localparam int unsigned IW = gp_idata_width;
  localparam int unsigned OW = gp_odata_width;
  localparam int unsigned SW = gp_idata_width + 1;

  localparam longint      SAT_MAX   = sat_limit(OW, 1'b1);
  localparam longint      SAT_MIN   = sat_limit(OW, 1'b0);
  localparam logic [63:0] SAT_MAX_V = SAT_MAX;
  localparam logic [63:0] SAT_MIN_V = SAT_MIN;

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;
  logic signed [63:0]   q_ext;
  logic                 clip_hi;
  logic                 clip_lo;

  logic [OW-1:0] q_data_q, q_data_d;
  logic          q_valid_q, q_valid_d;
  logic          sat_q, sat_d;
  logic          ovf_q, ovf_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic          rd_en;

`ifdef FILT_PPI_OQ_ROUND_EN
  localparam logic signed [SW-1:0] RND = {{(SW-1){1'b0}}, 1'b1} << (gp_frac_drop - 1);
`endif

  always_comb begin
`ifdef FILT_PPI_OQ_ROUND_EN
    sum = {i_data[IW-1], i_data} + RND;
`else
    sum = {i_data[IW-1], i_data};
`endif
    shifted = sum >>> gp_frac_drop;
    q_ext   = {{(64-SW){shifted[SW-1]}}, shifted};
    clip_hi = (q_ext > SAT_MAX);
    clip_lo = (q_ext < SAT_MIN);

    q_data_d = q_ext[OW-1:0];
    if (clip_hi) begin
      q_data_d = SAT_MAX_V[OW-1:0];
    end else if (clip_lo) begin
      q_data_d = SAT_MIN_V[OW-1:0];
    end
    q_valid_d = i_valid;
    sat_d     = i_valid && (clip_hi || clip_lo);

    rd_en = o_valid && i_ready;
    // Only a write that cannot be absorbed by a same-cycle read is lost.
    ovf_d = ovf_q || (q_valid_q && fifo_full && !rd_en);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q_data_q  <= '0;
      q_valid_q <= 1'b0;
      sat_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      q_data_q  <= q_data_d;
      q_valid_q <= q_valid_d;
      sat_q     <= sat_d;
      ovf_q     <= ovf_d;
    end
  end

  sync_fifo #(
    .gp_width (OW),
    .gp_depth (gp_fifo_depth)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (q_valid_q),
    .i_wr_data (q_data_q),
    .i_rd_en   (rd_en),
    .o_rd_data (o_data),
    .o_empty   (fifo_empty),
    .o_full    (fifo_full),
    .o_level   (o_level)
  );

  always_comb begin
    o_valid = !fifo_empty;
    o_sat   = sat_q;
    o_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_filt_ppi_oq.sv
module tb_filt_ppi_oq;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv;
  logic [25:0] id;
  logic [15:0] od;
  logic        ov;
  logic        ir;
  logic [3:0]  lvl;
  logic        sat;
  logic        ovf;

  always #5 clk = ~clk;

  filt_ppi_oq #(
    .gp_idata_width (26),
    .gp_odata_width (16),
    .gp_frac_drop   (10),
    .gp_fifo_depth  (8)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (iv),
    .i_data  (id),
    .o_data  (od),
    .o_valid (ov),
    .i_ready (ir),
    .o_level (lvl),
    .o_sat   (sat),
    .o_ovf   (ovf)
  );

  longint exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     max_lvl = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint quant(input longint x);
    longint s;
`ifdef FILT_PPI_OQ_ROUND_EN
    s = x + 512;
`else
    s = x;
`endif
    s = s >>> 10;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  // Monitor: every accepted output is compared with the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (int'(lvl) > max_lvl) max_lvl = int'(lvl);
      if (ov && ir) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL out_unexpected: got %0d, expected no output", $signed(od));
        end else begin
          check("out_data", longint'($signed(od)), exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input longint v, input longint e);
    iv = 1'b1;
    id = v[25:0];
    exp_q.push_back(e);
    tick();
    iv = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iv  = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    ir = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (!ov && exp_q.size() == 0) break;
      tick();
    end
    check(name, longint'(!ov && exp_q.size() == 0), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  longint dir_in  [4] = '{1536, -512, 33554431, -33554432};
`ifdef FILT_PPI_OQ_ROUND_EN
  longint dir_out [4] = '{2, 0, 32767, -32768};
  longint dir_sat [4] = '{0, 0, 1, 0};
`else
  longint dir_out [4] = '{1, -1, 32767, -32768};
  longint dir_sat [4] = '{0, 0, 0, 0};
`endif

  initial begin
    int sent;
    int cyc;
    logic signed [25:0] r26;
    longint d;

    rst = 1'b1; iv = 1'b0; ir = 1'b0; id = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_valid", ov, 0);
    check("rst_data", od, 0);
    check("rst_level", lvl, 0);
    check("rst_sat", sat, 0);
    check("rst_ovf", ovf, 0);

    // Quantization, latency and saturation pulses.
    ir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(dir_in[i], dir_out[i]);
      check("lat_n1_valid", ov, 0);
      check("sat_pulse", sat, dir_sat[i]);
      tick();
      check("lat_n2_valid", ov, 1);
      check("sat_clear", sat, 0);
      tick();
    end

    // Overflow: 10 strobes into a stalled 8-entry FIFO.
    ir = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      iv = 1'b1;
      id = 26'(k * 1024);
      if (k <= 8) exp_q.push_back(longint'(k));
      tick();
    end
    iv = 1'b0;
    tick(); tick();
    check("ovf_level", lvl, 8);
    check("ovf_flag", ovf, 1);
    drain("ovf_drain");
    check("ovf_sticky", ovf, 1);

    // Reset mid-stream with one sample in flight.
    ir = 1'b0;
    for (int k = 1; k <= 5; k++) send(longint'(k * 2048), longint'(2 * k));
    tick(); tick();
    check("mid_level5", lvl, 5);
    iv = 1'b1;
    id = 26'(999 * 1024);
    tick();
    iv = 1'b0;
    do_reset();
    check("mid_rst_valid", ov, 0);
    check("mid_rst_level", lvl, 0);
    check("mid_rst_ovf", ovf, 0);
    ir = 1'b1;
    repeat (5) tick();
    check("mid_no_ghost", ov, 0);

    // Full FIFO with concurrent read: no bubble, no overflow.
    ir = 1'b0;
    for (int k = 1; k <= 8; k++) send(longint'(k * 1024 + 100), longint'(k));
    tick(); tick();
    check("full_level", lvl, 8);
    iv = 1'b1;
    id = 26'(9 * 1024);
    exp_q.push_back(9);
    tick();
    for (int k = 10; k <= 20; k++) begin
      ir = 1'b1;
      iv = 1'b1;
      id = 26'(k * 1024);
      exp_q.push_back(longint'(k));
      tick();
      check("full_rd_level", lvl, 8);
      check("full_rd_valid", ov, 1);
      check("full_rd_ovf", ovf, 0);
    end
    iv = 1'b0;
    drain("full_rd_drain");

    // Wrap-around with random back-pressure; issue is gated so nothing drops.
    max_lvl = 0;
    sent = 0;
    cyc = 0;
    while (sent < 100 && cyc < 3000) begin
      ir = ($urandom_range(0, 3) != 0);
      if (exp_q.size() < 6) begin
        r26 = 26'($urandom);
        d = (sent % 2 == 1) ? longint'(r26) : longint'(r26 >>> 8);
        iv = 1'b1;
        id = d[25:0];
        exp_q.push_back(quant(d));
        sent++;
      end else begin
        iv = 1'b0;
      end
      tick();
      cyc++;
    end
    iv = 1'b0;
    check("wrap_sent", sent, 100);
    drain("wrap_drain");
    check("wrap_max_level_ok", longint'(max_lvl <= 8), 1);
    check("wrap_ovf", ovf, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
